decode_stage: RTL and testbench
===============================

# decode_stage

Second pipeline stage of the five-stage 32-bit MIPS-subset core. It sits directly downstream of the fetch stage and consumes its `instruction` / `PCnext` register, decodes the instruction, reads the register file, and resolves branches and jumps. It drives the fetch stage's `BRANCH` / `PCbranch` / `EN_REG` inputs, detects load-use and branch-operand hazards, and holds the ID/EX pipeline register.

## Interface
Parameters:
- none; all widths are fixed at 32-bit data and 5-bit register index.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low.
- `instruction` in 32: from the fetch stage register.
- `PCnext` in 32: address of the instruction following `instruction`.
- `wbRegWrite` in 1, `wbWriteReg` in 5, `wbWriteData` in 32: write-back port.
- `regWriteM` in 1, `writeRegM` in 5: MEM-stage destination, used for branch hazard detection.
- `BRANCH` out 1: redirect fetch (combinational).
- `PCbranch` out 32: redirect target (combinational).
- `EN_REG` out 1: fetch enable; 0 = stall (combinational).
- ID/EX register outputs:
  - `regWriteE`, `memToRegE`, `memReadE`, `memWriteE`, `aluSrcE`: 1 bit each.
  - `aluCtrlE` 3.
  - `rd1E`, `rd2E`, `immE`, `PCnextE`: 32 each.
  - `rsE`, `rtE`, `writeRegE`: 5 each.

## Operation
- Supported opcodes:
  - R-type 0x00, with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - lw 0x23, sw 0x2B, addi 0x08, beq 0x04, bne 0x05, j 0x02.
- `aluCtrl` encoding: ADD=0, SUB=1, AND=2, OR=3, SLT=4.
- Any undefined opcode or funct decodes as a NOP, with all control bits 0.
- Immediate: sign-extended `instruction[15:0]`.
- `writeReg`: `rd` for R-type, `rt` for lw and addi.
- Register file: 32x32, two combinational reads, one synchronous write.
  - `r0` reads 0 and ignores writes.
  - Write-through bypass: a read of the register being written this cycle returns `wbWriteData`.
- Branch resolution in decode:
  - beq taken when rd1 == rd2; bne taken when rd1 != rd2.
  - Branch target: `PCnext + (imm << 2)`, modulo 2^32.
  - j target: `{PCnext[31:28], instruction[25:0], 2'b00}`.
- Load-use stall: when `memReadE` is set and `rtE` (nonzero) equals the decode `rs` or `rt`.
- Branch stall: a beq or bne whose `rs`/`rt` (nonzero) matches `writeRegE` with `regWriteE` set, or matches `writeRegM` with `regWriteM` set.
- During a stall:
  - `EN_REG` = 0 and `BRANCH` = 0.
  - A bubble (all E-stage controls 0) is loaded into ID/EX.
- Squash: when a redirect is taken, the `squash` flag is set for one cycle.
  - The instruction arriving next cycle is the fall-through and is treated as a NOP: bubble into ID/EX, no branch, no stall.
  - A squashed instruction never generates a redirect.
- Simultaneous stall and redirect: the stall wins, and the redirect is evaluated again on the retry.

## Timing
- `BRANCH`, `PCbranch`, `EN_REG` are combinational in the decode cycle; fetch samples them on the same edge.
- ID/EX outputs update one clock after decode.
- Register-file write lands on the clock edge; a same-cycle read sees the new value through the bypass.
- Reset (asynchronous, mid-operation included) immediately forces:
  - all ID/EX outputs and the register file to 0;
  - `squash` to 0;
  - `EN_REG` to 1, `BRANCH` to 0, `PCbranch` to 0.
- Load-use costs 1 stall cycle. A branch-after-ALU costs 2 stall cycles; a branch-after-lw costs 2 (EX match, then MEM match).
- A taken branch or jump costs 1 squash cycle.

## Structure
- `decode_pkg`: opcode and funct constants, the `aluCtrl` encoding, and the control-bundle struct.
- Sub-module `reg_file_2r1w`: register file with `r0` hardwiring and write-through bypass.
- Top level contains the decoder, hazard unit, squash flop and ID/EX register.

## Test plan
- After reset, `addi r1,r0,5` then `add r2,r1,r1`, with r1 written back via `wbWrite*`: `rd1E` = 5 and `aluCtrlE` = 0; `r0` writes stay 0.
- `lw r3,0(r1)` followed by `add r4,r3,r3`: exactly one cycle with `EN_REG` = 0 and a bubble in ID/EX; the add issues the next cycle.
- `beq r1,r1,+3` with `PCnext` = 0x100: `BRANCH` = 1 and `PCbranch` = 0x10C; the next decoded instruction is squashed, producing a bubble and no redirect.
- `j 0x40` with `PCnext` = 0xF0000008: `PCbranch` = 0xF0000100.
- `addi r5,...` immediately followed by `bne r5,r0,...`: 2 stall cycles, then `BRANCH` is resolved with the written-back value.
- Assert `reset` low mid-stall: all outputs return to their reset values without waiting for a clock edge, and `EN_REG` = 1.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode definitions for the ID stage: opcode/funct constants, ALU
// control encoding, the decoded control bundle and the ID/EX register layout.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_ctrl_e;

    typedef struct packed {
        logic      reg_write;
        logic      mem_to_reg;
        logic      mem_read;
        logic      mem_write;
        logic      alu_src;
        alu_ctrl_e alu_ctrl;
        logic [4:0] write_reg;
        logic      branch_eq;
        logic      branch_ne;
        logic      jump;
    } ctrl_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc_next;
        logic [4:0]  rs;
        logic [4:0]  rt;
    } idex_t;

    // Anything not recognised falls out as an all-zero bundle, i.e. a NOP.
    function automatic ctrl_t decode_ctrl(input logic [31:0] instr);
        ctrl_t c;
        c = '0;
        case (instr[31:26])
            OP_RTYPE: begin
                c.reg_write = 1'b1;
                c.write_reg = instr[15:11];
                case (instr[5:0])
                    FN_ADD:  c.alu_ctrl = ALU_ADD;
                    FN_SUB:  c.alu_ctrl = ALU_SUB;
                    FN_AND:  c.alu_ctrl = ALU_AND;
                    FN_OR:   c.alu_ctrl = ALU_OR;
                    FN_SLT:  c.alu_ctrl = ALU_SLT;
                    default: c = '0;
                endcase
            end
            OP_LW: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.mem_read   = 1'b1;
                c.alu_src    = 1'b1;
                c.write_reg  = instr[20:16];
            end
            OP_SW: begin
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
            end
            OP_ADDI: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.write_reg = instr[20:16];
            end
            OP_BEQ: begin
                c.branch_eq = 1'b1;
                c.alu_ctrl  = ALU_SUB;
            end
            OP_BNE: begin
                c.branch_ne = 1'b1;
                c.alu_ctrl  = ALU_SUB;
            end
            OP_J:    c.jump = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/reg_file_2r1w.sv
// 32x32 register file: two combinational reads, one synchronous write,
// r0 hardwired to zero and a write-through bypass on both read ports.
module reg_file_2r1w (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o
);

    logic [31:0] regs_q [32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    function automatic logic [31:0] read_port(input logic [4:0] addr);
        if (addr == 5'd0)
            return '0;
        else if (we_i && (waddr_i == addr))
            return wdata_i;
        else
            return regs_q[addr];
    endfunction

    assign rdata1_o = read_port(raddr1_i);
    assign rdata2_o = read_port(raddr2_i);

endmodule

// File: rtl/decode_stage.sv
// ID stage of the five-stage MIPS-subset core: decode, register read, branch
// and jump resolution, hazard stalls, squash after redirect, ID/EX register.
module decode_stage
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [31:0] PCnext,
    input  logic        wbRegWrite,
    input  logic [4:0]  wbWriteReg,
    input  logic [31:0] wbWriteData,
    input  logic        regWriteM,
    input  logic [4:0]  writeRegM,
    output logic        BRANCH,
    output logic [31:0] PCbranch,
    output logic        EN_REG,
    output logic        regWriteE,
    output logic        memToRegE,
    output logic        memReadE,
    output logic        memWriteE,
    output logic        aluSrcE,
    output logic [2:0]  aluCtrlE,
    output logic [31:0] rd1E,
    output logic [31:0] rd2E,
    output logic [31:0] immE,
    output logic [31:0] PCnextE,
    output logic [4:0]  rsE,
    output logic [4:0]  rtE,
    output logic [4:0]  writeRegE
);

    logic [4:0]  rs, rt;
    ctrl_t       ctrl;
    logic [31:0] rd1, rd2, imm, target;
    logic        hit_rs, hit_rt, load_use, branch_hz, stall, taken;
    logic        squash_q, squash_d;
    idex_t       idex_q, idex_d;

    assign rs   = instruction[25:21];
    assign rt   = instruction[20:16];
    assign ctrl = decode_ctrl(instruction);
    assign imm  = {{16{instruction[15]}}, instruction[15:0]};

    reg_file_2r1w u_rf (
        .clk      (clk),
        .rst_n    (reset),
        .we_i     (wbRegWrite),
        .waddr_i  (wbWriteReg),
        .wdata_i  (wbWriteData),
        .raddr1_i (rs),
        .raddr2_i (rt),
        .rdata1_o (rd1),
        .rdata2_o (rd2)
    );

    // Branches compare in ID with no forwarding, so they wait until any
    // pending producer in EX or MEM has reached write-back.
    always_comb begin
        hit_rs = (rs != 5'd0) &&
                 ((idex_q.ctrl.reg_write && (idex_q.ctrl.write_reg == rs)) ||
                  (regWriteM && (writeRegM == rs)));
        hit_rt = (rt != 5'd0) &&
                 ((idex_q.ctrl.reg_write && (idex_q.ctrl.write_reg == rt)) ||
                  (regWriteM && (writeRegM == rt)));
        load_use  = idex_q.ctrl.mem_read && (idex_q.rt != 5'd0) &&
                    ((idex_q.rt == rs) || (idex_q.rt == rt));
        branch_hz = (ctrl.branch_eq || ctrl.branch_ne) && (hit_rs || hit_rt);
        stall     = !squash_q && (load_use || branch_hz);
        taken     = !squash_q && !stall &&
                    ((ctrl.branch_eq && (rd1 == rd2)) ||
                     (ctrl.branch_ne && (rd1 != rd2)) ||
                     ctrl.jump);
        target    = ctrl.jump ? {PCnext[31:28], instruction[25:0], 2'b00}
                              : PCnext + {imm[29:0], 2'b00};
    end

    assign BRANCH   = reset && taken;
    assign EN_REG   = !reset || !stall;
    assign PCbranch = reset ? target : 32'd0;
    assign squash_d = taken;

    always_comb begin
        idex_d.ctrl    = ctrl;
        idex_d.rd1     = rd1;
        idex_d.rd2     = rd2;
        idex_d.imm     = imm;
        idex_d.pc_next = PCnext;
        idex_d.rs      = rs;
        idex_d.rt      = rt;
        if (stall || squash_q) idex_d.ctrl = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            squash_q <= 1'b0;
            idex_q   <= '0;
        end else begin
            squash_q <= squash_d;
            idex_q   <= idex_d;
        end
    end

    assign regWriteE = idex_q.ctrl.reg_write;
    assign memToRegE = idex_q.ctrl.mem_to_reg;
    assign memReadE  = idex_q.ctrl.mem_read;
    assign memWriteE = idex_q.ctrl.mem_write;
    assign aluSrcE   = idex_q.ctrl.alu_src;
    assign aluCtrlE  = idex_q.ctrl.alu_ctrl;
    assign writeRegE = idex_q.ctrl.write_reg;
    assign rd1E      = idex_q.rd1;
    assign rd2E      = idex_q.rd2;
    assign immE      = idex_q.imm;
    assign PCnextE   = idex_q.pc_next;
    assign rsE       = idex_q.rs;
    assign rtE       = idex_q.rt;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: table of single-instruction decodes, hand-built
// hazard/squash/reset sequences, then random instructions against a model.
module tb_decode_stage;

    logic        clk, reset;
    logic [31:0] instruction, PCnext, wbWriteData;
    logic        wbRegWrite, regWriteM;
    logic [4:0]  wbWriteReg, writeRegM;
    logic        BRANCH, EN_REG;
    logic [31:0] PCbranch;
    logic        regWriteE, memToRegE, memReadE, memWriteE, aluSrcE;
    logic [2:0]  aluCtrlE;
    logic [31:0] rd1E, rd2E, immE, PCnextE;
    logic [4:0]  rsE, rtE, writeRegE;

    int nvec = 0;
    int errs = 0;

    decode_stage dut (
        .clk(clk), .reset(reset), .instruction(instruction), .PCnext(PCnext),
        .wbRegWrite(wbRegWrite), .wbWriteReg(wbWriteReg), .wbWriteData(wbWriteData),
        .regWriteM(regWriteM), .writeRegM(writeRegM),
        .BRANCH(BRANCH), .PCbranch(PCbranch), .EN_REG(EN_REG),
        .regWriteE(regWriteE), .memToRegE(memToRegE), .memReadE(memReadE),
        .memWriteE(memWriteE), .aluSrcE(aluSrcE), .aluCtrlE(aluCtrlE),
        .rd1E(rd1E), .rd2E(rd2E), .immE(immE), .PCnextE(PCnextE),
        .rsE(rsE), .rtE(rtE), .writeRegE(writeRegE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] e_ctl();
        return {regWriteE, memToRegE, memReadE, memWriteE, aluSrcE, aluCtrlE};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d, input logic [5:0] fn);
        return {6'h00, s, t, d, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] im);
        return {op, s, t, im};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] tg);
        return {6'h02, tg};
    endfunction

    // Control word layout: {regWrite, memToReg, memRead, memWrite, aluSrc, aluCtrl[2:0]}
    typedef struct packed {
        logic [7:0] ctl;
        logic [4:0] wr;
        logic       beq;
        logic       bne;
        logic       j;
    } rdec_t;

    function automatic rdec_t ref_dec(input logic [31:0] ins);
        rdec_t d;
        d = '0;
        case (ins[31:26])
            6'h00: begin
                case (ins[5:0])
                    6'h20: d.ctl = 8'h80;
                    6'h22: d.ctl = 8'h81;
                    6'h24: d.ctl = 8'h82;
                    6'h25: d.ctl = 8'h83;
                    6'h2A: d.ctl = 8'h84;
                    default: d.ctl = 8'h00;
                endcase
                if (d.ctl != 8'h00) d.wr = ins[15:11];
            end
            6'h23: begin d.ctl = 8'hE8; d.wr = ins[20:16]; end
            6'h2B: d.ctl = 8'h18;
            6'h08: begin d.ctl = 8'h88; d.wr = ins[20:16]; end
            6'h04: begin d.ctl = 8'h01; d.beq = 1'b1; end
            6'h05: begin d.ctl = 8'h01; d.bne = 1'b1; end
            6'h02: d.j = 1'b1;
            default: d = '0;
        endcase
        return d;
    endfunction

    typedef struct packed {
        logic [7:0]  ctl;
        logic [4:0]  wr;
        logic [31:0] rd1, rd2, imm, pcn;
        logic [4:0]  rs, rt;
    } mE_t;

    logic [31:0] mreg [32];
    mE_t         mE;
    logic        msq;

    function automatic logic [31:0] rv(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wbRegWrite && wbWriteReg == a) return wbWriteData;
        return mreg[a];
    endfunction

    function automatic logic dep(input logic [4:0] r);
        return (r != 5'd0) && ((mE.ctl[7] && mE.wr == r) || (regWriteM && writeRegM == r));
    endfunction

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pcn;
        logic [7:0]  ctl;
        logic [4:0]  wr;
        logic [31:0] imm;
        logic        br;
        logic [31:0] pcb;
    } vec_t;

    localparam int NV = 14;
    vec_t vt [NV];

    rdec_t       d;
    logic [31:0] ins, v1, v2, sx, tgt;
    logic [4:0]  rs, rt;
    logic        lu, bh, st, tk;

    initial begin
        vt[0]  = '{enc_r(5'd1, 5'd2, 5'd3, 6'h20), 32'h4,   8'h80, 5'd3, 32'h0000_1820, 1'b0, 32'h0};
        vt[1]  = '{enc_r(5'd1, 5'd2, 5'd3, 6'h22), 32'h8,   8'h81, 5'd3, 32'h0000_1822, 1'b0, 32'h0};
        vt[2]  = '{enc_r(5'd1, 5'd2, 5'd3, 6'h24), 32'hC,   8'h82, 5'd3, 32'h0000_1824, 1'b0, 32'h0};
        vt[3]  = '{enc_r(5'd1, 5'd2, 5'd3, 6'h25), 32'h10,  8'h83, 5'd3, 32'h0000_1825, 1'b0, 32'h0};
        vt[4]  = '{enc_r(5'd1, 5'd2, 5'd3, 6'h2A), 32'h14,  8'h84, 5'd3, 32'h0000_182A, 1'b0, 32'h0};
        vt[5]  = '{enc_r(5'd1, 5'd2, 5'd3, 6'h21), 32'h18,  8'h00, 5'd0, 32'h0000_1821, 1'b0, 32'h0};
        vt[6]  = '{enc_i(6'h23, 5'd1, 5'd3, 16'hFFFC), 32'h1C, 8'hE8, 5'd3, 32'hFFFF_FFFC, 1'b0, 32'h0};
        vt[7]  = '{enc_i(6'h2B, 5'd1, 5'd3, 16'h0008), 32'h20, 8'h18, 5'd0, 32'h0000_0008, 1'b0, 32'h0};
        vt[8]  = '{enc_i(6'h08, 5'd1, 5'd4, 16'hFFFF), 32'h24, 8'h88, 5'd4, 32'hFFFF_FFFF, 1'b0, 32'h0};
        vt[9]  = '{enc_i(6'h3F, 5'd1, 5'd7, 16'h1234), 32'h28, 8'h00, 5'd0, 32'h0000_1234, 1'b0, 32'h0};
        vt[10] = '{enc_i(6'h04, 5'd0, 5'd0, 16'h0003), 32'h100, 8'h01, 5'd0, 32'h0000_0003, 1'b1, 32'h10C};
        vt[11] = '{enc_i(6'h05, 5'd1, 5'd2, 16'hFFFF), 32'h200, 8'h01, 5'd0, 32'hFFFF_FFFF, 1'b1, 32'h1FC};
        vt[12] = '{enc_i(6'h04, 5'd1, 5'd2, 16'h0005), 32'h300, 8'h01, 5'd0, 32'h0000_0005, 1'b0, 32'h0};
        vt[13] = '{enc_j(26'h40), 32'hF000_0008, 8'h00, 5'd0, 32'h0000_0040, 1'b1, 32'hF000_0100};

        reset = 1'b1; instruction = '0; PCnext = '0;
        wbRegWrite = 1'b0; wbWriteReg = '0; wbWriteData = '0;
        regWriteM = 1'b0; writeRegM = '0;
        #1 reset = 1'b0;
        #2;
        chk("rst_EN_REG", EN_REG, 1'b1);
        chk("rst_BRANCH", BRANCH, 1'b0);
        chk("rst_PCbranch", PCbranch, 32'h0);
        chk("rst_ctl", e_ctl(), 8'h00);

        // addi r1,r0,5 while r0 is being written: r0 must still read 0
        reset = 1'b1;
        instruction = enc_i(6'h08, 5'd0, 5'd1, 16'd5); PCnext = 32'h4;
        wbRegWrite = 1'b1; wbWriteReg = 5'd0; wbWriteData = 32'd7;
        #1 chk("addi_EN_REG", EN_REG, 1'b1);
        step;
        chk("addi_ctl", e_ctl(), 8'h88);
        chk("addi_wr", writeRegE, 5'd1);
        chk("addi_imm", immE, 32'd5);
        chk("addi_rd1_r0", rd1E, 32'd0);

        // add r2,r1,r1 with r1=5 arriving through write-back this cycle
        instruction = enc_r(5'd1, 5'd1, 5'd2, 6'h20);
        wbRegWrite = 1'b1; wbWriteReg = 5'd1; wbWriteData = 32'd5;
        step;
        chk("add_rd1_bypass", rd1E, 32'd5);
        chk("add_aluCtrl", aluCtrlE, 3'd0);
        chk("add_wr", writeRegE, 5'd2);
        wbRegWrite = 1'b0;
        instruction = enc_r(5'd0, 5'd1, 5'd2, 6'h20);
        step;
        chk("r0_still_zero", rd1E, 32'd0);
        chk("r1_stored", rd2E, 32'd5);

        for (int i = 0; i < NV; i++) begin
            instruction = vt[i].ins; PCnext = vt[i].pcn;
            #1;
            chk($sformatf("tbl%0d_BRANCH", i), BRANCH, vt[i].br);
            if (vt[i].br) chk($sformatf("tbl%0d_PCbranch", i), PCbranch, vt[i].pcb);
            step;
            chk($sformatf("tbl%0d_ctl", i), e_ctl(), vt[i].ctl);
            chk($sformatf("tbl%0d_wr", i), writeRegE, vt[i].wr);
            chk($sformatf("tbl%0d_imm", i), immE, vt[i].imm);
            chk($sformatf("tbl%0d_pcn", i), PCnextE, vt[i].pcn);
            instruction = '0;
            step;
        end

        // beq r1,r1,+3 then a would-be-taken beq that must be squashed
        instruction = enc_i(6'h04, 5'd1, 5'd1, 16'd3); PCnext = 32'h100;
        #1;
        chk("beq_BRANCH", BRANCH, 1'b1);
        chk("beq_PCbranch", PCbranch, 32'h10C);
        step;
        instruction = enc_i(6'h04, 5'd0, 5'd0, 16'd8); PCnext = 32'h104;
        #1;
        chk("squash_BRANCH", BRANCH, 1'b0);
        chk("squash_EN_REG", EN_REG, 1'b1);
        step;
        chk("squash_bubble", e_ctl(), 8'h00);

        // lw r3,0(r1) then add r4,r3,r3: one stall, then issue
        instruction = enc_i(6'h23, 5'd1, 5'd3, 16'd0); PCnext = 32'h40;
        step;
        instruction = enc_r(5'd3, 5'd3, 5'd4, 6'h20); PCnext = 32'h44;
        #1;
        chk("lu_EN_REG", EN_REG, 1'b0);
        chk("lu_BRANCH", BRANCH, 1'b0);
        step;
        chk("lu_bubble", {e_ctl(), writeRegE}, 13'h0);
        #1 chk("lu_retry_EN_REG", EN_REG, 1'b1);
        step;
        chk("lu_issue", {e_ctl(), writeRegE}, {8'h80, 5'd4});

        // addi r5,r0,9 then bne r5,r0,+2: EX stall, MEM stall, then resolve
        instruction = enc_i(6'h08, 5'd0, 5'd5, 16'd9); PCnext = 32'h48;
        step;
        instruction = enc_i(6'h05, 5'd5, 5'd0, 16'd2); PCnext = 32'h300;
        regWriteM = 1'b1; writeRegM = 5'd4;
        #1;
        chk("bh1_EN_REG", EN_REG, 1'b0);
        chk("bh1_BRANCH", BRANCH, 1'b0);
        step;
        regWriteM = 1'b1; writeRegM = 5'd5;
        #1;
        chk("bh2_EN_REG", EN_REG, 1'b0);
        chk("bh2_BRANCH", BRANCH, 1'b0);
        step;
        regWriteM = 1'b0;
        wbRegWrite = 1'b1; wbWriteReg = 5'd5; wbWriteData = 32'd9;
        #1;
        chk("bh3_EN_REG", EN_REG, 1'b1);
        chk("bh3_BRANCH", BRANCH, 1'b1);
        chk("bh3_PCbranch", PCbranch, 32'h308);
        step;
        wbRegWrite = 1'b0;
        instruction = '0;
        step;

        // Reset asserted in the middle of a load-use stall
        instruction = enc_i(6'h23, 5'd1, 5'd3, 16'd4); PCnext = 32'h500;
        step;
        instruction = enc_r(5'd3, 5'd3, 5'd4, 6'h20); PCnext = 32'h504;
        #1 chk("rs_pre_EN_REG", EN_REG, 1'b0);
        reset = 1'b0;
        #1;
        chk("rs_EN_REG", EN_REG, 1'b1);
        chk("rs_BRANCH", BRANCH, 1'b0);
        chk("rs_PCbranch", PCbranch, 32'h0);
        chk("rs_ctl", e_ctl(), 8'h00);
        chk("rs_data", {rd1E, immE}, 64'h0);
        chk("rs_pcn", PCnextE, 32'h0);
        reset = 1'b1;
        instruction = enc_r(5'd1, 5'd1, 5'd2, 6'h20);
        step;
        chk("rs_regfile_clear", rd1E, 32'd0);

        // Randomised run against the reference model
        reset = 1'b0;
        #1 reset = 1'b1;
        for (int k = 0; k < 32; k++) mreg[k] = '0;
        mE = '0; msq = 1'b0;
        for (int n = 0; n < 600; n++) begin
            ins = $urandom;
            rs  = 5'($urandom_range(0, 7));
            rt  = ($urandom_range(0, 3) == 0) ? rs : 5'($urandom_range(0, 7));
            case ($urandom_range(0, 8))
                0, 1: begin
                    ins[31:26] = 6'h00;
                    ins[15:11] = 5'($urandom_range(0, 7));
                    case ($urandom_range(0, 5))
                        0: ins[5:0] = 6'h20;
                        1: ins[5:0] = 6'h22;
                        2: ins[5:0] = 6'h24;
                        3: ins[5:0] = 6'h25;
                        4: ins[5:0] = 6'h2A;
                        default: ins[5:0] = 6'($urandom_range(0, 63));
                    endcase
                end
                2: ins[31:26] = 6'h23;
                3: ins[31:26] = 6'h2B;
                4: ins[31:26] = 6'h08;
                5: ins[31:26] = 6'h04;
                6: ins[31:26] = 6'h05;
                7: ins[31:26] = 6'h02;
                default: ins[31:26] = 6'($urandom_range(0, 63));
            endcase
            if (ins[31:26] != 6'h02) begin
                ins[25:21] = rs;
                ins[20:16] = rt;
            end
            instruction = ins;
            PCnext      = $urandom;
            wbRegWrite  = 1'($urandom_range(0, 1));
            wbWriteReg  = 5'($urandom_range(0, 7));
            wbWriteData = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            regWriteM   = ($urandom_range(0, 3) == 0);
            writeRegM   = 5'($urandom_range(0, 7));
            #1;
            d  = ref_dec(ins);
            rs = ins[25:21];
            rt = ins[20:16];
            v1 = rv(rs);
            v2 = rv(rt);
            sx = {{16{ins[15]}}, ins[15:0]};
            lu = mE.ctl[5] && (mE.rt != 5'd0) && (mE.rt == rs || mE.rt == rt);
            bh = (d.beq || d.bne) && (dep(rs) || dep(rt));
            st = !msq && (lu || bh);
            tk = !msq && !st && (d.j || (d.beq && v1 == v2) || (d.bne && v1 != v2));
            tgt = d.j ? {PCnext[31:28], ins[25:0], 2'b00} : PCnext + sx * 32'd4;
            chk("rnd_BRANCH", BRANCH, tk);
            chk("rnd_EN_REG", EN_REG, !st);
            if (tk) chk("rnd_PCbranch", PCbranch, tgt);
            mE.ctl = (st || msq) ? 8'h00 : d.ctl;
            mE.wr  = (st || msq) ? 5'd0 : d.wr;
            mE.rd1 = v1; mE.rd2 = v2; mE.imm = sx; mE.pcn = PCnext;
            mE.rs  = rs; mE.rt = rt;
            if (wbRegWrite && wbWriteReg != 5'd0) mreg[wbWriteReg] = wbWriteData;
            msq = tk;
            step;
            chk("rnd_ctl", {e_ctl(), writeRegE}, {mE.ctl, mE.wr});
            chk("rnd_rd", {rd1E, rd2E}, {mE.rd1, mE.rd2});
            chk("rnd_imm_pcn", {immE, PCnextE}, {mE.imm, mE.pcn});
            chk("rnd_rs_rt", {rsE, rtE}, {mE.rs, mE.rt});
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule
